// File: rtl/unidade_excecao_if.sv
// Signal bundle between the exception sequencer and the surrounding datapath/memory.
// master: the sequencer (drives the mux selector and PC load); slave: the datapath side.
interface unidade_excecao_if;
    logic        excOpcode;
    logic        excOverflow;
    logic        excDivZero;
    logic [31:0] valorPC;
    logic [31:0] memDataOut;
    logic [3:0]  MuxAddr;
    logic        busy;
    logic        pcWrite;
    logic [31:0] pcValue;
    logic [31:0] epc;
    logic [1:0]  causa;

    modport master (
        input  excOpcode, excOverflow, excDivZero, valorPC, memDataOut,
        output MuxAddr, busy, pcWrite, pcValue, epc, causa
    );

    modport slave (
        output excOpcode, excOverflow, excDivZero, valorPC, memDataOut,
        input  MuxAddr, busy, pcWrite, pcValue, epc, causa
    );
endinterface

// File: rtl/unidade_excecao.sv
// Exception sequencer: saves EPC, reads the handler byte at vector 253/254/255 and loads PC.
// Latency: flag edge to pcWrite is MEM_LATENCY+1 cycles; busy stalls control; flags while busy are dropped.
module unidade_excecao #(
    parameter int         MEM_LATENCY  = 2,
    parameter logic [3:0] SEL_NORMAL   = 4'b0000,
    parameter logic [3:0] SEL_OPCODE   = 4'b0011,
    parameter logic [3:0] SEL_OVERFLOW = 4'b0100,
    parameter logic [3:0] SEL_DIVZERO  = 4'b0101
) (
    input  logic                  clk,
    input  logic                  reset,
    unidade_excecao_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  causa_q, causa_d;
    logic [3:0]  cnt_q;
    logic [31:0] epc_q;
    logic [31:0] handler_q;
    logic        exc_any;
    logic        accept;
    logic        unused_mem_hi;

    assign exc_any       = bus.excOpcode | bus.excOverflow | bus.excDivZero;
    assign accept        = (state_q == IDLE) && exc_any;
    assign unused_mem_hi = ^bus.memDataOut[31:8];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (exc_any) state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Opcode wins over overflow, which wins over divide-by-zero.
    always_comb begin
        sel_d   = SEL_DIVZERO;
        causa_d = 2'b11;
        if (bus.excOpcode) begin
            sel_d   = SEL_OPCODE;
            causa_d = 2'b01;
        end else if (bus.excOverflow) begin
            sel_d   = SEL_OVERFLOW;
            causa_d = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= SEL_NORMAL;
            causa_q   <= 2'b00;
            cnt_q     <= 4'd0;
            epc_q     <= 32'd0;
            handler_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sel_q   <= sel_d;
                causa_q <= causa_d;
                epc_q   <= bus.valorPC - 32'd4;
                cnt_q   <= CNT_INIT;
            end else if (state_q == WAIT) begin
                if (cnt_q == 4'd0) begin
                    handler_q <= {24'b0, bus.memDataOut[7:0]};
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

    // Outputs depend only on state and registers, never directly on the flags.
    assign bus.MuxAddr = (state_q == IDLE) ? SEL_NORMAL : sel_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.pcWrite = (state_q == LOAD);
    assign bus.pcValue = handler_q;
    assign bus.epc     = epc_q;
    assign bus.causa   = causa_q;

endmodule

// File: tb/tb_unidade_excecao.sv
// Bench for unidade_excecao: two instances (MEM_LATENCY 2 and 1) sharing flags, each with its own latency-accurate memory.
module tb_unidade_excecao;

    logic clk;
    logic reset;

    unidade_excecao_if bus0 ();
    unidade_excecao_if bus1 ();

    unidade_excecao #(.MEM_LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    unidade_excecao #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining busy cycles per instance plus the architectural outputs.
    int          lat    [2] = '{2, 1};
    int          m_rem  [2];
    logic [3:0]  m_sel  [2];
    logic [1:0]  m_causa[2];
    logic [31:0] m_epc  [2];
    logic [31:0] m_pcv  [2];
    logic [31:0] m_pend [2];
    logic [7:0]  vecb   [2][3];
    logic [3:0]  hist   [2][16];
    bit          rand_vec = 1'b0;

    typedef struct {
        logic [2:0]  fl;      // {opcode, overflow, divzero}
        logic [31:0] pc;
        logic [7:0]  byt;
        logic [3:0]  e_sel;
        logic [1:0]  e_causa;
        logic [31:0] e_epc;
        logic [31:0] e_pcv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rem[d] = 0; m_sel[d] = 4'd0; m_causa[d] = 2'd0;
            m_epc[d] = 32'd0; m_pcv[d] = 32'd0; m_pend[d] = 32'd0;
            for (int k = 0; k < 16; k++) hist[d][k] = 4'd0;
        end
    endtask

    function automatic logic [31:0] mem_word(input int d, input logic [3:0] a);
        logic [31:0] w;
        w = $urandom;
        if (a >= 4'd3 && a <= 4'd5) w[7:0] = vecb[d][a - 4'd3];
        return w;
    endfunction

    task automatic cmp_dut(input int d, input logic [3:0] mux, input logic bsy, input logic pw,
                           input logic [31:0] pcv, input logic [31:0] epc, input logic [1:0] cs);
        check($sformatf("d%0d_MuxAddr", d), {28'd0, mux}, {28'd0, (m_rem[d] > 0) ? m_sel[d] : 4'd0});
        check($sformatf("d%0d_busy", d), {31'd0, bsy}, {31'd0, (m_rem[d] > 0)});
        check($sformatf("d%0d_pcWrite", d), {31'd0, pw}, {31'd0, (m_rem[d] == 1)});
        check($sformatf("d%0d_pcValue", d), pcv, m_pcv[d]);
        check($sformatf("d%0d_epc", d), epc, m_epc[d]);
        check($sformatf("d%0d_causa", d), {30'd0, cs}, {30'd0, m_causa[d]});
    endtask

    // One clock: drive at negedge, let the edge happen, advance model and memory, compare.
    task automatic step(input logic [2:0] fl, input logic [31:0] pc);
        int ci;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            if (rand_vec && m_rem[d] == 0)
                for (int i = 0; i < 3; i++) vecb[d][i] = 8'($urandom);
        {bus0.excOpcode, bus0.excOverflow, bus0.excDivZero} = fl;
        {bus1.excOpcode, bus1.excOverflow, bus1.excDivZero} = fl;
        bus0.valorPC = pc;
        bus1.valorPC = pc;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_rem[d] = 0; m_sel[d] = 4'd0; m_causa[d] = 2'd0;
                m_epc[d] = 32'd0; m_pcv[d] = 32'd0;
            end else if (m_rem[d] > 0) begin
                m_rem[d]--;
                if (m_rem[d] == 1) m_pcv[d] = m_pend[d];
            end else if (fl != 3'b000) begin
                ci = fl[2] ? 0 : (fl[1] ? 1 : 2);
                m_rem[d]   = lat[d] + 1;
                m_sel[d]   = 4'(3 + ci);
                m_causa[d] = 2'(ci + 1);
                m_epc[d]   = pc - 32'd4;
                m_pend[d]  = {24'd0, vecb[d][ci]};
            end
        end
        #1;
        for (int k = 15; k > 0; k--) begin
            hist[0][k] = hist[0][k-1];
            hist[1][k] = hist[1][k-1];
        end
        hist[0][0] = bus0.MuxAddr;
        hist[1][0] = bus1.MuxAddr;
        bus0.memDataOut = mem_word(0, hist[0][lat[0]-1]);
        bus1.memDataOut = mem_word(1, hist[1][lat[1]-1]);
        cmp_dut(0, bus0.MuxAddr, bus0.busy, bus0.pcWrite, bus0.pcValue, bus0.epc, bus0.causa);
        cmp_dut(1, bus1.MuxAddr, bus1.busy, bus1.pcWrite, bus1.pcValue, bus1.epc, bus1.causa);
    endtask

    vec_t tbl[5];
    int   pw_cnt[2];
    int   bz_cnt[2];

    initial begin
        tbl[0] = '{3'b010, 32'h0000_0108, 8'h7C, 4'b0100, 2'b10, 32'h0000_0104, 32'h0000_007C};
        tbl[1] = '{3'b111, 32'h0000_2000, 8'h33, 4'b0011, 2'b01, 32'h0000_1FFC, 32'h0000_0033};
        tbl[2] = '{3'b001, 32'h0000_0000, 8'hA0, 4'b0101, 2'b11, 32'hFFFF_FFFC, 32'h0000_00A0};
        tbl[3] = '{3'b011, 32'h0000_0040, 8'hFF, 4'b0100, 2'b10, 32'h0000_003C, 32'h0000_00FF};
        tbl[4] = '{3'b101, 32'h0000_0004, 8'h01, 4'b0011, 2'b01, 32'h0000_0000, 32'h0000_0001};

        reset = 1'b0;
        {bus0.excOpcode, bus0.excOverflow, bus0.excDivZero} = 3'b000;
        {bus1.excOpcode, bus1.excOverflow, bus1.excDivZero} = 3'b000;
        bus0.valorPC = 32'd0;    bus1.valorPC = 32'd0;
        bus0.memDataOut = 32'd0; bus1.memDataOut = 32'd0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) vecb[d][i] = 8'd0;
        model_reset();
        #1;
        cmp_dut(0, bus0.MuxAddr, bus0.busy, bus0.pcWrite, bus0.pcValue, bus0.epc, bus0.causa);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) step(3'b000, 32'h0000_1000);

        // Directed vectors with hand-computed results (instance with MEM_LATENCY=2)
        for (int v = 0; v < 5; v++) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 3; i++) vecb[d][i] = tbl[v].byt;
            step(tbl[v].fl, tbl[v].pc);
            for (int c = 1; c <= 3; c++) begin
                check($sformatf("tbl%0d_c%0d_MuxAddr", v, c), {28'd0, bus0.MuxAddr}, {28'd0, tbl[v].e_sel});
                check($sformatf("tbl%0d_c%0d_pcWrite", v, c), {31'd0, bus0.pcWrite}, {31'd0, (c == 3)});
                if (c < 3) step(3'b000, tbl[v].pc);
            end
            check($sformatf("tbl%0d_pcValue", v), bus0.pcValue, tbl[v].e_pcv);
            check($sformatf("tbl%0d_epc", v), bus0.epc, tbl[v].e_epc);
            check($sformatf("tbl%0d_causa", v), {30'd0, bus0.causa}, {30'd0, tbl[v].e_causa});
            step(3'b000, tbl[v].pc);
            check($sformatf("tbl%0d_idle_MuxAddr", v), {28'd0, bus0.MuxAddr}, 32'd0);
            check($sformatf("tbl%0d_idle_busy", v), {31'd0, bus0.busy}, 32'd0);
        end

        // Flag pulsed while busy is dropped; count pulses and busy cycles
        rand_vec = 1'b1;
        repeat (3) step(3'b000, 32'd0);
        pw_cnt = '{0, 0};
        bz_cnt = '{0, 0};
        for (int c = 0; c < 6; c++) begin
            step((c == 0) ? 3'b010 : ((c == 1) ? 3'b001 : 3'b000), 32'h0000_0200);
            pw_cnt[0] += int'(bus0.pcWrite); bz_cnt[0] += int'(bus0.busy);
            pw_cnt[1] += int'(bus1.pcWrite); bz_cnt[1] += int'(bus1.busy);
        end
        check("ign_causa_d0", {30'd0, bus0.causa}, 32'd2);
        check("ign_causa_d1", {30'd0, bus1.causa}, 32'd2);
        check("ign_pw_d0", pw_cnt[0], 1);
        check("ign_pw_d1", pw_cnt[1], 1);
        check("ign_busy_d0", bz_cnt[0], 3);
        check("ign_busy_d1", bz_cnt[1], 2);

        // Held flag re-triggers after exactly one idle cycle
        for (int c = 0; c < 8; c++) step(3'b001, 32'h0000_0300);
        repeat (4) step(3'b000, 32'd0);

        // Reset mid-WAIT aborts at once
        step(3'b100, 32'h0000_0400);
        step(3'b000, 32'h0000_0400);
        #2;
        reset = 1'b0;
        #1;
        check("rst_MuxAddr", {28'd0, bus0.MuxAddr}, 32'd0);
        check("rst_busy", {31'd0, bus0.busy}, 32'd0);
        check("rst_pcWrite", {31'd0, bus0.pcWrite}, 32'd0);
        check("rst_pcValue", bus0.pcValue, 32'd0);
        check("rst_epc", bus0.epc, 32'd0);
        check("rst_causa", {30'd0, bus0.causa}, 32'd0);
        model_reset();
        repeat (2) step(3'b000, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        pw_cnt = '{0, 0};
        for (int c = 0; c < 4; c++) begin
            step(3'b000, 32'd0);
            pw_cnt[0] += int'(bus0.pcWrite);
        end
        check("rst_no_pw", pw_cnt[0], 0);
        step(3'b001, 32'h0000_0500);
        repeat (4) step(3'b000, 32'd0);
        check("rst_after_epc", bus0.epc, 32'h0000_04FC);
        check("rst_after_causa", {30'd0, bus0.causa}, 32'd3);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [2:0] f;
            f = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            step(f, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
